bist_stim_compactor: RTL and testbench
======================================

Name: bist_stim_compactor

Overview:
- Test-side partner for the sequential benchmark cores: it drives their primary inputs and reads their primary outputs.
- An 18-bit LFSR generates pseudo-random stimulus patterns; a 16-bit MISR compacts the DUT response into a signature.
- When the run finishes, the signature is compared against a golden value, giving a pass/fail result for trojan-detection runs.
- Sits between the run controller (start/done handshake) and one benchmark instance.

Parameters:
- IN_W, 18, DUT primary-input width (LFSR width; polynomial fixed for 18).
- OUT_W, 1, DUT primary-output width (OUT_W <= MISR_W).
- MISR_W, 16, signature width (polynomial fixed for 16).
- NUM_PATTERNS, 256, number of patterns applied per run (1..65535).
- DUT_LATENCY, 1, cycles from dut_in to the corresponding dut_out (0..3).
- LFSR_SEED, 18'h00001, LFSR value loaded at run start (must be nonzero).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle run request; sampled only in IDLE.
- golden_sig  in  MISR_W  expected signature; sampled in COMPARE.
- dut_reset_n  out  1  active-low reset to the DUT.
- dut_in  out  IN_W  stimulus to the DUT.
- dut_out  in  OUT_W  DUT response.
- busy  out  1  high from DUT_RST through COMPARE.
- done  out  1  one-cycle pulse when the result is valid.
- pass  out  1  signature == golden_sig; held until next start.
- signature  out  MISR_W  final MISR value; held until next start.
- pattern_count  out  16  patterns applied in the current or last run.

Behaviour:
Reset (reset low, asynchronous):
- state=IDLE; lfsr=LFSR_SEED; misr=0; counters=0.
- dut_reset_n=0, dut_in=0, busy=0, done=0, pass=0, signature=0, pattern_count=0.

LFSR:
- Fibonacci, shift left: next = {lfsr[16:0], lfsr[17]^lfsr[10]} (x^18+x^11+1).
- dut_in = lfsr while in RUN, 0 in every other state.

MISR:
- Updated only when the compaction enable is set.
- next = {misr[14:0], misr[15]^misr[14]^misr[12]^misr[3]} ^ zero-extended dut_out.

FSM:
- IDLE:
  - dut_reset_n=1.
  - start=1 -> DUT_RST; load lfsr=LFSR_SEED; clear misr, pattern_count and the sample counter.
- DUT_RST:
  - dut_reset_n=0 for exactly 2 cycles, then -> RUN.
- RUN:
  - Lasts NUM_PATTERNS cycles; dut_in=lfsr.
  - lfsr advances and pattern_count increments every cycle.
  - -> DRAIN when pattern_count reaches NUM_PATTERNS (-> COMPARE directly if DUT_LATENCY=0).
- DRAIN:
  - Lasts DUT_LATENCY cycles; dut_in=0.
- Compaction enable:
  - Set on the cycles from RUN cycle index DUT_LATENCY through the end of DRAIN.
  - Exactly NUM_PATTERNS samples are compacted.
- COMPARE (1 cycle):
  - signature<=misr; pass<=(misr==golden_sig); done<=1 on the next cycle.
  - -> IDLE.
- busy=1 in DUT_RST, RUN, DRAIN and COMPARE.

Timing and boundary rules:
- Run length: start at cycle t -> done high at cycle t+1+2+NUM_PATTERNS+DUT_LATENCY+1.
- done pulses for exactly 1 cycle.
- start while busy is ignored and does not queue.
- start in the same cycle done is high: accepted (state is IDLE).
- NUM_PATTERNS=1: a single pattern is applied and a single sample compacted.
- LFSR never reaches 0 for a nonzero seed; after 2^18-1 steps it wraps back to the seed.
- pattern_count saturates at NUM_PATTERNS and holds after done.
- reset asserted mid-run: immediate return to IDLE with reset values; the partial signature is discarded; no done pulse.

Test Plan:
- NUM_PATTERNS=4, DUT_LATENCY=1, stub DUT with dut_out=dut_in[0] registered, start at cycle 0 -> dut_reset_n low cycles 1-2; dut_in=18'h00001,18'h00002,18'h00004,18'h00008 on cycles 3-6; dut_in=0 cycle 7; done at cycle 9; pattern_count=4.
- dut_out tied to 0, golden_sig=0 -> signature=16'h0000, pass=1, done single-cycle.
- Same run with golden_sig=16'h0001 -> pass=0, signature=16'h0000.
- Bench-model DUT (16-bit XOR-accumulate core, out=state[0]) with golden from the reference model -> pass=1; flip one DUT flop via force mid-run -> pass=0.
- start pulsed during RUN and DRAIN -> no restart; pattern_count sequence unchanged; exactly one done pulse.
- reset deasserted-then-asserted at RUN cycle 2 -> dut_in=0 and dut_reset_n=0 immediately; busy=0, signature=0; a new start after release runs cleanly from LFSR_SEED.

Source files
------------

// File: rtl/bist_stim_compactor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : bist_stim_compactor                                     |
// | Desc   : LFSR stimulus source and MISR response compactor that   |
// |          checks a benchmark core against a golden signature.     |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module bist_stim_compactor #(
  parameter int unsigned     IN_W         = 18,
  parameter int unsigned     OUT_W        = 1,
  parameter int unsigned     MISR_W       = 16,
  parameter int unsigned     NUM_PATTERNS = 256,
  parameter int unsigned     DUT_LATENCY  = 1,
  parameter logic [IN_W-1:0] LFSR_SEED    = IN_W'(1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MISR_W-1:0] golden_sig,
  output logic              dut_reset_n,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [15:0]       pattern_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DUT_RST = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_COMPARE = 3'd4
  } state_t;

  localparam logic [15:0] c_num_pat  = 16'(NUM_PATTERNS);
  localparam logic [15:0] c_last_pat = 16'(NUM_PATTERNS - 1);
  localparam logic [1:0]  c_lat_m1   = 2'(DUT_LATENCY - 1);
  localparam logic [16:0] c_lat      = 17'(DUT_LATENCY);

  state_t              state_q, state_d;
  logic [IN_W-1:0]     lfsr_q, lfsr_d;
  logic [MISR_W-1:0]   misr_q, misr_d;
  logic [15:0]         pattern_count_q, pattern_count_d;
  logic [15:0]         sample_cnt_q, sample_cnt_d;
  logic                rst_cnt_q, rst_cnt_d;
  logic [1:0]          drain_cnt_q, drain_cnt_d;
  logic                dut_reset_n_q, dut_reset_n_d;
  logic [IN_W-1:0]     dut_in_q, dut_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [MISR_W-1:0]   signature_q, signature_d;

  logic [MISR_W-1:0]   w_dut_ext;
  logic [IN_W-1:0]     w_lfsr_next;
  logic                w_misr_fb;
  logic [MISR_W-1:0]   w_misr_next;
  logic [16:0]         w_elapsed;
  logic                w_cmp_en;

  generate
    if (OUT_W < MISR_W) begin : g_pad
      assign w_dut_ext = {{(MISR_W - OUT_W){1'b0}}, dut_out};
    end else begin : g_nopad
      assign w_dut_ext = dut_out;
    end
  endgenerate

  // x^18 + x^11 + 1 and x^16 + x^15 + x^13 + x^4 + 1 feedback taps.
  assign w_lfsr_next = {lfsr_q[IN_W-2:0], lfsr_q[17] ^ lfsr_q[10]};
  assign w_misr_fb   = misr_q[15] ^ misr_q[14] ^ misr_q[12] ^ misr_q[3];
  assign w_misr_next = {misr_q[MISR_W-2:0], w_misr_fb} ^ w_dut_ext;

  // Cycles since the first RUN cycle; the response to pattern k arrives at
  // elapsed index k + DUT_LATENCY, which also covers runs shorter than the latency.
  assign w_elapsed = {1'b0, pattern_count_q} + {15'd0, drain_cnt_q};
  assign w_cmp_en  = ((state_q == S_RUN) || (state_q == S_DRAIN)) &&
                     (w_elapsed >= c_lat) && (sample_cnt_q < c_num_pat);

  always_comb begin
    state_d         = state_q;
    lfsr_d          = lfsr_q;
    misr_d          = misr_q;
    pattern_count_d = pattern_count_q;
    sample_cnt_d    = sample_cnt_q;
    rst_cnt_d       = rst_cnt_q;
    drain_cnt_d     = drain_cnt_q;
    pass_d          = pass_q;
    signature_d     = signature_q;
    done_d          = 1'b0;

    if (w_cmp_en) begin
      misr_d       = w_misr_next;
      sample_cnt_d = sample_cnt_q + 16'd1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d         = S_DUT_RST;
          lfsr_d          = LFSR_SEED;
          misr_d          = '0;
          pattern_count_d = '0;
          sample_cnt_d    = '0;
          rst_cnt_d       = 1'b0;
          drain_cnt_d     = '0;
          pass_d          = 1'b0;
          signature_d     = '0;
        end
      end
      S_DUT_RST: begin
        rst_cnt_d = 1'b1;
        if (rst_cnt_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        lfsr_d          = w_lfsr_next;
        pattern_count_d = pattern_count_q + 16'd1;
        if (pattern_count_q == c_last_pat) begin
          state_d = (DUT_LATENCY == 0) ? S_COMPARE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == c_lat_m1) begin
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        signature_d = misr_q;
        pass_d      = (misr_q == golden_sig);
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with state_q.
    dut_reset_n_d = (state_d != S_DUT_RST);
    dut_in_d      = (state_d == S_RUN) ? lfsr_d : '0;
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      lfsr_q          <= LFSR_SEED;
      misr_q          <= '0;
      pattern_count_q <= '0;
      sample_cnt_q    <= '0;
      rst_cnt_q       <= 1'b0;
      drain_cnt_q     <= '0;
      dut_reset_n_q   <= 1'b0;
      dut_in_q        <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      signature_q     <= '0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      misr_q          <= misr_d;
      pattern_count_q <= pattern_count_d;
      sample_cnt_q    <= sample_cnt_d;
      rst_cnt_q       <= rst_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      dut_reset_n_q   <= dut_reset_n_d;
      dut_in_q        <= dut_in_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      signature_q     <= signature_d;
    end
  end

  assign dut_reset_n   = dut_reset_n_q;
  assign dut_in        = dut_in_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign signature     = signature_q;
  assign pattern_count = pattern_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bist_stim_compactor.sv
`default_nettype none
// Bench for bist_stim_compactor: a short run (4 patterns, latency 1) with
// hand-derived traces and a longer run (40 patterns, latency 2) against a model.
module tb_bist_stim_compactor;

  localparam int N1 = 4;
  localparam int L1 = 1;
  localparam int N2 = 40;
  localparam int L2 = 2;
  localparam logic [17:0] SEED2 = 18'h2A5F3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic reset;

  // instance 1
  logic        start1;
  logic [15:0] golden1;
  logic        dut_reset_n1, busy1, done1, pass1;
  logic [17:0] dut_in1;
  logic [0:0]  dut_out1;
  logic [15:0] signature1, pattern_count1;

  // instance 2
  logic        start2;
  logic [15:0] golden2;
  logic        dut_reset_n2, busy2, done2, pass2;
  logic [17:0] dut_in2;
  logic [0:0]  dut_out2;
  logic [15:0] signature2, pattern_count2;

  bist_stim_compactor #(
    .IN_W(18), .OUT_W(1), .MISR_W(16), .NUM_PATTERNS(N1), .DUT_LATENCY(L1),
    .LFSR_SEED(18'h00001)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .golden_sig(golden1),
    .dut_reset_n(dut_reset_n1), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(signature1),
    .pattern_count(pattern_count1)
  );

  bist_stim_compactor #(
    .IN_W(18), .OUT_W(1), .MISR_W(16), .NUM_PATTERNS(N2), .DUT_LATENCY(L2),
    .LFSR_SEED(SEED2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .golden_sig(golden2),
    .dut_reset_n(dut_reset_n2), .dut_in(dut_in2), .dut_out(dut_out2),
    .busy(busy2), .done(done2), .pass(pass2), .signature(signature2),
    .pattern_count(pattern_count2)
  );

  // Benchmark stand-ins. mode1: 0 = tied low, 1 = registered dut_in[0],
  // 2 = XOR-accumulate core with a bit-flip injection port.
  logic [1:0]  mode1;
  logic [15:0] inject1;
  logic [15:0] core1_q;
  logic        stub1_q;
  always_ff @(posedge clk) begin
    if (!dut_reset_n1) begin
      core1_q <= '0;
      stub1_q <= 1'b0;
    end else begin
      core1_q <= {core1_q[14:0], core1_q[15]} ^ dut_in1[15:0] ^ inject1;
      stub1_q <= dut_in1[0];
    end
  end
  assign dut_out1 = (mode1 == 2'd0) ? 1'b0 : (mode1 == 2'd1) ? stub1_q : core1_q[0];

  // Same core with an extra output flop: two cycles of latency.
  logic [15:0] core2_q;
  logic        dly2_q;
  always_ff @(posedge clk) begin
    if (!dut_reset_n2) begin
      core2_q <= '0;
      dly2_q  <= 1'b0;
    end else begin
      core2_q <= {core2_q[14:0], core2_q[15]} ^ dut_in2[15:0];
      dly2_q  <= core2_q[0];
    end
  end
  assign dut_out2 = dly2_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] sig;
    logic        pass;
    logic [15:0] pc;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  // Result monitors: every done pulse must match the oldest pending run.
  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        chk("done1_spurious", done1, 1'b0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("signature1", signature1, e.sig);
        chk("pass1", pass1, e.pass);
        chk("pattern_count1", pattern_count1, e.pc);
        chk("done1_cycle", cyc, e.cyc);
      end
    end
    if (done2) begin
      if (q2.size() == 0) begin
        chk("done2_spurious", done2, 1'b0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("signature2", signature2, e.sig);
        chk("pass2", pass2, e.pass);
        chk("pattern_count2", pattern_count2, e.pc);
        chk("done2_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic logic [15:0] model_sig2();
    logic [17:0] l;
    logic [15:0] core;
    logic [15:0] m;
    l    = SEED2;
    core = '0;
    m    = '0;
    for (int i = 0; i < N2; i++) begin
      core = {core[14:0], core[15]} ^ l[15:0];
      m    = {m[14:0], m[15] ^ m[14] ^ m[12] ^ m[3]} ^ {15'd0, core[0]};
      l    = {l[16:0], l[17] ^ l[10]};
    end
    return m;
  endfunction

  // Start at cycle 0 (k counts cycles after start): reset low k=1..2, patterns
  // k=3..6, drain k=7, compare k=8, done k=9.
  task automatic run1(input logic [1:0] mode, input logic [15:0] gold,
                      input logic [15:0] esig, input logic epass, input bit immediate,
                      input int inject_at, input int extra_a, input int extra_b,
                      input int abort_at);
    exp_t        e;
    logic [17:0] pat [4];
    pat[0] = 18'h00001;
    pat[1] = 18'h00002;
    pat[2] = 18'h00004;
    pat[3] = 18'h00008;
    if (!immediate) @(negedge clk);
    mode1   = mode;
    golden1 = gold;
    start1  = 1'b1;
    if (abort_at == 0) begin
      e.sig  = esig;
      e.pass = epass;
      e.pc   = 16'(N1);
      e.cyc  = cyc + 4 + N1 + L1;
      q1.push_back(e);
    end
    for (int k = 1; k <= N1 + L1 + 4; k++) begin
      @(negedge clk);
      start1  = (k == extra_a) || (k == extra_b);
      inject1 = (k == inject_at) ? 16'h0001 : 16'h0000;
      if (k == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_dut_in", dut_in1, 18'h0);
        chk("abort_dut_reset_n", dut_reset_n1, 1'b0);
        chk("abort_busy", busy1, 1'b0);
        chk("abort_signature", signature1, 16'h0);
        chk("abort_pass", pass1, 1'b0);
        chk("abort_pattern_count", pattern_count1, 16'h0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done1, 1'b0);
        reset = 1'b1;
        return;
      end
      chk("dut_reset_n1", dut_reset_n1, (k <= 2) ? 1'b0 : 1'b1);
      chk("dut_in1", dut_in1, (k >= 3 && k <= 6) ? pat[k-3] : 18'h0);
      chk("busy1", busy1, (k <= 8) ? 1'b1 : 1'b0);
      chk("pattern_count_trace1", pattern_count1,
          (k <= 3) ? 16'd0 : (k <= 7) ? 16'(k - 3) : 16'd4);
      if (k == N1 + L1 + 4) chk("done1_high", done1, 1'b1);
    end
    start1  = 1'b0;
    inject1 = 16'h0;
  endtask

  task automatic run2(input logic [15:0] gold, input logic epass);
    exp_t        e;
    logic [17:0] l;
    @(negedge clk);
    golden2 = gold;
    start2  = 1'b1;
    e.sig   = model_sig2();
    e.pass  = epass;
    e.pc    = 16'(N2);
    e.cyc   = cyc + 4 + N2 + L2;
    q2.push_back(e);
    l = SEED2;
    for (int k = 1; k <= N2 + L2 + 4; k++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (k >= 3 && k < 3 + N2) begin
        chk("dut_in2", dut_in2, l);
        l = {l[16:0], l[17] ^ l[10]};
      end
      if (k == N2 + L2 + 4) chk("done2_high", done2, 1'b1);
    end
  endtask

  initial begin
    reset   = 1'b0;
    start1  = 1'b0;
    start2  = 1'b0;
    golden1 = '0;
    golden2 = '0;
    mode1   = 2'd0;
    inject1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_dut_reset_n", dut_reset_n1, 1'b0);
    chk("rst_dut_in", dut_in1, 18'h0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_pass", pass1, 1'b0);
    chk("rst_signature", signature1, 16'h0);
    chk("rst_pattern_count", pattern_count1, 16'h0);
    chk("rst_dut_in2", dut_in2, 18'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_dut_reset_n", dut_reset_n1, 1'b1);
    chk("idle_busy", busy1, 1'b0);

    // registered dut_in[0] stub: samples 1,0,0,0 -> 16'h0008
    run1(2'd1, 16'h0008, 16'h0008, 1'b1, 1'b0, 0, 0, 0, 0);
    // tied-low response, started in the done cycle of the previous run
    run1(2'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 0, 0, 0, 0);
    run1(2'd0, 16'h0001, 16'h0000, 1'b0, 1'b0, 0, 0, 0, 0);
    // XOR core: samples 1,0,0,0 -> 16'h0008; with a flip after cycle 4: 1,1,0,0 -> 16'h000C
    run1(2'd2, 16'h0008, 16'h0008, 1'b1, 1'b0, 0, 0, 0, 0);
    run1(2'd2, 16'h0008, 16'h000C, 1'b0, 1'b0, 4, 0, 0, 0);
    // start pulsed in RUN (k=4) and DRAIN (k=7) must not restart
    run1(2'd1, 16'h0008, 16'h0008, 1'b1, 1'b0, 0, 4, 7, 0);
    repeat (3) @(negedge clk);
    chk("hold_pass", pass1, 1'b1);
    chk("hold_signature", signature1, 16'h0008);
    chk("hold_pattern_count", pattern_count1, 16'd4);
    chk("hold_done_low", done1, 1'b0);
    // reset at RUN cycle 2, then a clean run from the seed
    run1(2'd1, 16'h0008, 16'h0000, 1'b0, 1'b0, 0, 0, 0, 5);
    run1(2'd1, 16'h0008, 16'h0008, 1'b1, 1'b0, 0, 0, 0, 0);

    run2(model_sig2(), 1'b1);
    run2(model_sig2() ^ 16'h0001, 1'b0);

    repeat (4) @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
